// File: rtl/cavlc_run_level_scan.sv
// Reverse-zigzag coefficient scanner for CAVLC: emits level/run buffer writes
// and the TotalCoeff / TrailingOnes / TotalZeros statistics for one block.
module cavlc_run_level_scan #(
  parameter int COEFF_W   = 12,
  parameter int ADDRWIDTH = 4,
  parameter int RUNWIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 coeff_valid,
  input  logic [COEFF_W-1:0]   coeff_i,
  input  logic                 coeff_last,
  output logic                 ready,
  output logic                 lvl_we,
  output logic [ADDRWIDTH-1:0] lvl_addr,
  output logic [COEFF_W-1:0]   lvl_data,
  output logic                 run_we,
  output logic [ADDRWIDTH-1:0] run_addr,
  output logic [RUNWIDTH-1:0]  run_data,
  output logic [4:0]           total_coeff,
  output logic [1:0]           trailing_ones,
  output logic [3:0]           total_zeros,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t state_q, state_d;

  logic [4:0]          tc_q, tc_d;
  logic [RUNWIDTH-1:0] zero_cnt_q, zero_cnt_d;
  logic [1:0]          t1_q, t1_d;
  logic                t1_open_q, t1_open_d;
  logic [3:0]          tz_q, tz_d;
  logic [4:0]          cnt_q, cnt_d;

  logic                 ready_q, ready_d;
  logic                 lvl_we_q, lvl_we_d;
  logic [ADDRWIDTH-1:0] lvl_addr_q, lvl_addr_d;
  logic [COEFF_W-1:0]   lvl_data_q, lvl_data_d;
  logic                 run_we_q, run_we_d;
  logic [ADDRWIDTH-1:0] run_addr_q, run_addr_d;
  logic [RUNWIDTH-1:0]  run_data_q, run_data_d;
  logic [4:0]           total_coeff_q, total_coeff_d;
  logic [1:0]           trailing_ones_q, trailing_ones_d;
  logic [3:0]           total_zeros_q, total_zeros_d;
  logic                 done_q, done_d;

  logic accept;
  logic nonzero;
  logic abs_one;

  // start always wins, so a coefficient offered alongside it is dropped
  assign accept  = (state_q == SCAN) && coeff_valid && !start;
  assign nonzero = (coeff_i != '0);
  assign abs_one = (coeff_i == COEFF_W'(1)) || (coeff_i == {COEFF_W{1'b1}});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = SCAN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        SCAN:    if (accept && (coeff_last || cnt_q == 5'd15)) state_d = FLUSH;
        FLUSH:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    ready_d         = (state_d == SCAN);
    lvl_we_d        = accept && nonzero;
    lvl_addr_d      = ADDRWIDTH'(tc_q);
    lvl_data_d      = coeff_i;
    run_we_d        = (tc_q != 5'd0) &&
                      ((accept && nonzero) || (state_q == FLUSH && !start));
    run_addr_d      = ADDRWIDTH'(tc_q - 5'd1);
    run_data_d      = zero_cnt_q;
    done_d          = (state_q == DONE) && !start;
    total_coeff_d   = total_coeff_q;
    trailing_ones_d = trailing_ones_q;
    total_zeros_d   = total_zeros_q;
    if (start) begin
      total_coeff_d   = '0;
      trailing_ones_d = '0;
      total_zeros_d   = '0;
    end else if (state_q == DONE) begin
      total_coeff_d   = tc_q;
      trailing_ones_d = t1_q;
      total_zeros_d   = tz_q;
    end
  end

  // Block statistics
  always_comb begin
    tc_d       = tc_q;
    zero_cnt_d = zero_cnt_q;
    t1_d       = t1_q;
    t1_open_d  = t1_open_q;
    tz_d       = tz_q;
    cnt_d      = cnt_q;
    if (start) begin
      tc_d       = '0;
      zero_cnt_d = '0;
      t1_d       = '0;
      t1_open_d  = 1'b1;
      tz_d       = '0;
      cnt_d      = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 5'd1;
      if (nonzero) begin
        tc_d       = tc_q + 5'd1;
        zero_cnt_d = '0;
        if (t1_open_q && abs_one && t1_q != 2'd3) begin
          t1_d = t1_q + 2'd1;
        end else begin
          t1_open_d = 1'b0;
        end
      end else if (tc_q != 5'd0) begin
        // zeros ahead of the first nonzero in reverse scan are not part of the block
        zero_cnt_d = zero_cnt_q + RUNWIDTH'(1);
        tz_d       = tz_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q            <= '0;
      zero_cnt_q      <= '0;
      t1_q            <= '0;
      t1_open_q       <= 1'b0;
      tz_q            <= '0;
      cnt_q           <= '0;
      ready_q         <= 1'b0;
      lvl_we_q        <= 1'b0;
      lvl_addr_q      <= '0;
      lvl_data_q      <= '0;
      run_we_q        <= 1'b0;
      run_addr_q      <= '0;
      run_data_q      <= '0;
      total_coeff_q   <= '0;
      trailing_ones_q <= '0;
      total_zeros_q   <= '0;
      done_q          <= 1'b0;
    end else begin
      tc_q            <= tc_d;
      zero_cnt_q      <= zero_cnt_d;
      t1_q            <= t1_d;
      t1_open_q       <= t1_open_d;
      tz_q            <= tz_d;
      cnt_q           <= cnt_d;
      ready_q         <= ready_d;
      lvl_we_q        <= lvl_we_d;
      lvl_addr_q      <= lvl_addr_d;
      lvl_data_q      <= lvl_data_d;
      run_we_q        <= run_we_d;
      run_addr_q      <= run_addr_d;
      run_data_q      <= run_data_d;
      total_coeff_q   <= total_coeff_d;
      trailing_ones_q <= trailing_ones_d;
      total_zeros_q   <= total_zeros_d;
      done_q          <= done_d;
    end
  end

  assign ready         = ready_q;
  assign lvl_we        = lvl_we_q;
  assign lvl_addr      = lvl_addr_q;
  assign lvl_data      = lvl_data_q;
  assign run_we        = run_we_q;
  assign run_addr      = run_addr_q;
  assign run_data      = run_data_q;
  assign total_coeff   = total_coeff_q;
  assign trailing_ones = trailing_ones_q;
  assign total_zeros   = total_zeros_q;
  assign done          = done_q;

endmodule

// File: tb/tb_cavlc_run_level_scan.sv
// Directed bench for cavlc_run_level_scan: logs buffer writes and done pulses,
// then compares them against hand-computed results per block.
module tb_cavlc_run_level_scan;

  localparam int COEFF_W = 12;
  localparam int AW      = 4;
  localparam int RW      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic coeff_valid = 1'b0;
  logic [COEFF_W-1:0] coeff_i = '0;
  logic coeff_last = 1'b0;
  logic ready, lvl_we, run_we, done;
  logic [AW-1:0] lvl_addr, run_addr;
  logic [COEFF_W-1:0] lvl_data;
  logic [RW-1:0] run_data;
  logic [4:0] total_coeff;
  logic [1:0] trailing_ones;
  logic [3:0] total_zeros;

  cavlc_run_level_scan #(.COEFF_W(COEFF_W), .ADDRWIDTH(AW), .RUNWIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coeff_valid(coeff_valid),
    .coeff_i(coeff_i), .coeff_last(coeff_last), .ready(ready),
    .lvl_we(lvl_we), .lvl_addr(lvl_addr), .lvl_data(lvl_data),
    .run_we(run_we), .run_addr(run_addr), .run_data(run_data),
    .total_coeff(total_coeff), .trailing_ones(trailing_ones),
    .total_zeros(total_zeros), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  int lvl_log [16];
  int run_log [16];
  int lvl_cnt, run_cnt, order_err, done_cnt, done_cyc;
  int done_tc, done_t1, done_tz;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done logger, sampled mid-cycle
  always @(posedge clk) begin
    #3;
    if (lvl_we) begin
      if (int'(lvl_addr) != lvl_cnt) order_err++;
      lvl_log[lvl_addr] = int'($signed(lvl_data));
      lvl_cnt++;
    end
    if (run_we) begin
      if (int'(run_addr) != run_cnt) order_err++;
      run_log[run_addr] = int'(run_data);
      run_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_tc  = int'(total_coeff);
      done_t1  = int'(trailing_ones);
      done_tz  = int'(total_zeros);
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 16; i++) begin
      lvl_log[i] = -999;
      run_log[i] = -999;
    end
    lvl_cnt = 0; run_cnt = 0; order_err = 0; done_cnt = 0;
    done_cyc = -1; done_tc = -1; done_t1 = -1; done_tz = -1;
  endtask

  // One cycle of stimulus, applied at the falling edge
  task automatic drive(input logic v, input int c, input logic l, input logic s);
    @(negedge clk);
    coeff_valid = v;
    coeff_i     = c[COEFF_W-1:0];
    coeff_last  = l;
    start       = s;
    if (v && l && !s) last_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_stats(input string tag, input int tc, input int t1, input int tz);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_tc"}, done_tc, tc);
    chk({tag, "_t1"}, done_t1, t1);
    chk({tag, "_tz"}, done_tz, tz);
    chk({tag, "_order"}, order_err, 0);
  endtask

  int blk1 [16] = '{0,0,0,0,0,0,0,0,0,1,0,0,-1,0,3,0};
  int blk4 [5]  = '{-1,1,1,-1,2};

  initial begin
    clear_logs();
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_lvl_we", lvl_we, 0);
    chk("rst_done", done, 0);
    chk("rst_tc", total_coeff, 0);
    rst_n = 1'b1;
    idle(2);

    // Block 1: mixed stream with a trailing zero
    clear_logs();
    drive(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, blk1[i], i == 15, 1'b0);
      if (i == 0) chk("b1_ready_scan", ready, 1);
    end
    idle(6);
    chk("b1_lvl_cnt", lvl_cnt, 3);
    chk("b1_lvl0", lvl_log[0], 1);
    chk("b1_lvl1", lvl_log[1], -1);
    chk("b1_lvl2", lvl_log[2], 3);
    chk("b1_run_cnt", run_cnt, 3);
    chk("b1_run0", run_log[0], 2);
    chk("b1_run1", run_log[1], 1);
    chk("b1_run2", run_log[2], 1);
    check_stats("b1", 3, 2, 4);
    chk("b1_done_lat", done_cyc - last_cyc, 2);
    chk("b1_hold_tc", total_coeff, 3);
    chk("b1_idle_ready", ready, 0);

    // Block 2: all zeros
    clear_logs();
    drive(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, 0, i == 15, 1'b0);
    idle(6);
    chk("b2_lvl_cnt", lvl_cnt, 0);
    chk("b2_run_cnt", run_cnt, 0);
    check_stats("b2", 0, 0, 0);
    chk("b2_done_lat", done_cyc - last_cyc, 2);

    // Block 3: sixteen +1, no coeff_last; extras must be ignored
    clear_logs();
    drive(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, 1, 1'b0, 1'b0);
    drive(1'b1, 5, 1'b0, 1'b0);
    chk("b3_ready_flush", ready, 0);
    drive(1'b1, 5, 1'b1, 1'b0);
    idle(6);
    chk("b3_lvl_cnt", lvl_cnt, 16);
    chk("b3_lvl15", lvl_log[15], 1);
    chk("b3_run_cnt", run_cnt, 16);
    chk("b3_run0", run_log[0], 0);
    chk("b3_run15", run_log[15], 0);
    check_stats("b3", 16, 3, 0);

    // Block 4: trailing-ones saturation
    clear_logs();
    drive(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, blk4[i], i == 4, 1'b0);
    idle(6);
    chk("b4_lvl_cnt", lvl_cnt, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("b4_lvl%0d", i), lvl_log[i], blk4[i]);
    chk("b4_run_cnt", run_cnt, 5);
    chk("b4_run4", run_log[4], 0);
    check_stats("b4", 5, 3, 0);

    // Block 5: abort mid-scan; restart coefficient offered with start is dropped
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b1, 7, 1'b0, 1'b0);
    drive(1'b1, 0, 1'b0, 1'b0);
    drive(1'b1, 4, 1'b0, 1'b0);
    drive(1'b1, 9, 1'b0, 1'b1);
    clear_logs();
    drive(1'b1, 5, 1'b1, 1'b0);
    idle(6);
    chk("b5_lvl_cnt", lvl_cnt, 1);
    chk("b5_lvl0", lvl_log[0], 5);
    chk("b5_run_cnt", run_cnt, 1);
    chk("b5_run0", run_log[0], 0);
    check_stats("b5", 1, 0, 0);

    // Block 6: reset mid-scan, then a gapped block from scratch
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b1, 3, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, -2, 1'b0, 1'b0);
    @(negedge clk);
    coeff_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("r_ready", ready, 0);
    chk("r_lvl_we", lvl_we, 0);
    chk("r_run_we", run_we, 0);
    chk("r_tc", total_coeff, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    idle(4);
    chk("r_no_writes", lvl_cnt + run_cnt + done_cnt, 0);
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b1, 0, 1'b0, 1'b0);
    drive(1'b1, 2, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 0, 1'b0, 1'b0);
    drive(1'b1, 1, 1'b1, 1'b0);
    idle(6);
    chk("b6_lvl_cnt", lvl_cnt, 2);
    chk("b6_lvl0", lvl_log[0], 2);
    chk("b6_lvl1", lvl_log[1], 1);
    chk("b6_run_cnt", run_cnt, 2);
    chk("b6_run0", run_log[0], 1);
    chk("b6_run1", run_log[1], 0);
    check_stats("b6", 2, 0, 1);
    chk("b6_done_lat", done_cyc - last_cyc, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
